mantissa_adder_unit: RTL
========================

Name: mantissa_adder_unit

Overview:
- Callee-side responder for the FP adder controller's mantissa-add handshake.
- Accepts two 25-bit operands on valid and adds them over several cycles in SEG_W-bit ripple segments.
- Returns the 25-bit sum and carry-out with an ack, using a four-phase valid/ack protocol.
- Sits beside the adder controller inside the FPU adder path.

Parameters:
- WIDTH, 25: operand and result width in bits.
- SEG_W, 5: bits added per compute cycle. WIDTH must be a multiple of SEG_W; this is checked at elaboration.
- NSEG, WIDTH/SEG_W: number of compute cycles. Derived localparam, not overridable.

Ports:
- CLK  in  1  system clock. Single clock domain.
- RST  in  1  reset, synchronous, active-high.
- Adder_datain1  in  WIDTH  operand A. Sampled only on accept.
- Adder_datain2  in  WIDTH  operand B. Already two's-complemented by the caller for effective subtraction. Sampled only on accept.
- Adder_valid  in  1  request. Held high by the caller until it sees ack.
- Adder_dataout  out  WIDTH  sum[WIDTH-1:0].
- Adder_carryout  out  1  carry out of bit WIDTH-1.
- Adder_ack  out  1  result valid / completion.
- Debug  out  2  current state encoding.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - State goes to IDLE.
  - Adder_ack=0, Adder_dataout=0, Adder_carryout=0.
  - Segment index=0, internal carry=0, operand registers=0.
  - Reset mid-operation aborts the operation; no ack is ever issued for it.
- All outputs are registered.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - If Adder_valid=1 at the edge: latch both operands, clear carry and index, go to COMPUTE.
  - Otherwise stay in IDLE. Ack stays 0.
- COMPUTE:
  - Each cycle adds segment idx (bits idx*SEG_W +: SEG_W) of the latched operands plus the carry.
  - Writes the segment into the sum register, updates carry, increments idx.
  - On the last segment (idx=NSEG-1): go to DONE, set Adder_ack=1, drive Adder_dataout=sum and Adder_carryout=carry.
  - Input operand changes during COMPUTE are ignored.
  - Adder_valid dropping during COMPUTE does not abort the operation.
- DONE:
  - Ack stays 1 and the outputs stay stable while Adder_valid=1.
  - When Adder_valid=0 at an edge: ack returns to 0 and the state goes to IDLE.
  - Adder_dataout and Adder_carryout hold their value until the next accept.
- Latency: ack is first high NSEG+1 cycles after the cycle in which valid is first seen high (6 cycles at defaults).
- The caller's registered valid drops one cycle after it sees ack, so ack is nominally high for 2 cycles.
- If valid is already low on entry to DONE, ack is high for exactly 1 cycle.
- Back-to-back: a new valid is accepted only in IDLE, so the minimum turnaround is 1 IDLE cycle after ack falls.
- Arithmetic: unsigned modulo 2^WIDTH. The carry-out is the true bit WIDTH, with no saturation. Sign interpretation is the caller's responsibility.
- Debug encoding: IDLE=0, COMPUTE=1, DONE=2.

Decomposition:
- Shared package fpu_pkg holds:
  - enum adder_unit_state_t {IDLE, COMPUTE, DONE}
  - constant MANT_ADD_W=25
  - the elaboration check helper for WIDTH % SEG_W
- Sub-module adder_segment: purely combinational SEG_W-bit full adder (a, b, cin -> sum, cout). Instantiated once, muxed by the segment index.

Test Plan:
- Reset: RST=1 for 2 cycles with valid=1 -> ack=0, dataout=0, carryout=0, Debug=0; no accept while RST is high.
- Basic add: 25'h0800000 + 25'h0400000 -> dataout=25'h0C00000, carry=0. Ack first high exactly 6 cycles after valid is seen; ack falls 1 cycle after valid drops.
- Full ripple: 25'h1FFFFFF + 25'h0000001 -> dataout=0, carry=1. Carry must propagate across all 5 segments.
- Effective subtract: 25'h0C00000 + 25'h1E00000 -> dataout=25'h0A00000, carry=1.
- Handshake hold and back-to-back:
  - Hold valid 4 cycles past ack -> ack and dataout stay stable.
  - Drop valid -> ack=0 next cycle.
  - Re-raise valid with new operands -> a second correct result.
  - Changing operands mid-COMPUTE has no effect on the result.
- Abort: assert RST in the 3rd COMPUTE cycle -> next state IDLE, ack never rises, outputs 0; the following operation completes correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU adder path
package fpu_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } adder_unit_state_t;
    localparam int MANT_ADD_W = 25;
    function automatic bit seg_width_ok(input int width, input int seg_w);
        return seg_w > 0 && width > 0 && width % seg_w == 0;
    endfunction
endpackage

// File: rtl/adder_segment.sv
// adder_segment: combinational SEG_W-bit full adder slice
module adder_segment #(
    parameter int SEG_W = 5
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
endmodule

// File: rtl/mantissa_adder_unit.sv
// mantissa_adder_unit: multi-cycle segmented mantissa adder with four-phase valid/ack
module mantissa_adder_unit
    import fpu_pkg::*;
#(
    parameter int WIDTH = MANT_ADD_W,
    parameter int SEG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Adder_datain1,
    input  logic [WIDTH-1:0] Adder_datain2,
    input  logic             Adder_valid,
    output logic [WIDTH-1:0] Adder_dataout,
    output logic             Adder_carryout,
    output logic             Adder_ack,
    output logic [1:0]       Debug
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam int IDX_W = NSEG > 1 ? $clog2(NSEG) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSEG - 1);

    generate
        if (!seg_width_ok(WIDTH, SEG_W)) begin : g_bad_seg
            $error("WIDTH must be a positive multiple of SEG_W");
        end
    endgenerate

    adder_unit_state_t state;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_next;
    logic [IDX_W-1:0] idx;
    logic carry_q;
    logic [SEG_W-1:0] seg_sum;
    logic seg_cout;

    adder_segment #(.SEG_W(SEG_W)) u_seg (
        .a   (a_q[int'(idx)*SEG_W +: SEG_W]),
        .b   (b_q[int'(idx)*SEG_W +: SEG_W]),
        .cin (carry_q),
        .sum (seg_sum),
        .cout(seg_cout)
    );

    // merge the current segment result into the partial sum
    always_comb begin
        sum_next = sum_q;
        sum_next[int'(idx)*SEG_W +: SEG_W] = seg_sum;
    end

    // handshake FSM: accept in IDLE, ripple one segment per cycle, hold result until valid drops
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            sum_q          <= '0;
            carry_q        <= 1'b0;
            idx            <= '0;
            Adder_ack      <= 1'b0;
            Adder_dataout  <= '0;
            Adder_carryout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Adder_valid) begin
                    a_q     <= Adder_datain1;
                    b_q     <= Adder_datain2;
                    carry_q <= 1'b0;
                    idx     <= '0;
                    state   <= COMPUTE;
                end
                COMPUTE: begin
                    sum_q   <= sum_next;
                    carry_q <= seg_cout;
                    idx     <= idx + 1'b1;
                    if (idx == LAST) begin
                        state          <= DONE;
                        Adder_ack      <= 1'b1;
                        Adder_dataout  <= sum_next;
                        Adder_carryout <= seg_cout;
                    end
                end
                DONE: if (!Adder_valid) begin
                    Adder_ack <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Debug = state;
endmodule
